// File: rtl/spi_lcd_rx_module.sv
// SPI responder for the 12864 LCD link: recovers command/data bytes, tracks the
// page/column pointer and emits frame-RAM writes for the received display data.
module spi_lcd_rx_module #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COL_MAX     = 127,
    parameter int unsigned PAGE_MAX    = 7
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] SPI_In,
    output logic [7:0] Rx_Data,
    output logic       Rx_A0,
    output logic       Rx_Valid,
    output logic       Cmd_Valid,
    output logic       Wr_En,
    output logic [9:0] Wr_Addr,
    output logic [7:0] Wr_Data,
    output logic       Frame_Err
);

    localparam logic [6:0] ColLast = 7'(COL_MAX);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e state_q, state_d;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] spi_s;
    logic       sclk_d_q, cs_d_q;
    logic       sclk_rise_q, cs_rise_q, cs_fall_q, sda_q, a0_q;

    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       a0_byte_q, a0_byte_d;
    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_a0_q, rx_a0_d;
    logic       rx_valid_q, rx_valid_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       wr_en_q, wr_en_d;
    logic [9:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= SPI_In;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign spi_s = sync_q[SYNC_STAGES-1];

    // Edge strobes are registered together with SDA/A0 so the sampled bit stays aligned.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sclk_d_q    <= 1'b0;
            cs_d_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            sda_q       <= 1'b0;
            a0_q        <= 1'b0;
        end else begin
            sclk_d_q    <= spi_s[1];
            cs_d_q      <= spi_s[3];
            sclk_rise_q <= spi_s[1] & ~sclk_d_q & ~spi_s[3];
            cs_rise_q   <= spi_s[3] & ~cs_d_q;
            cs_fall_q   <= ~spi_s[3] & cs_d_q;
            sda_q       <= spi_s[0];
            a0_q        <= spi_s[2];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cs_fall_q) state_d = StShift;
            StShift: begin
                if (cs_rise_q)                           state_d = StIdle;
                else if (sclk_rise_q && cnt_q == 3'd7)   state_d = StDone;
            end
            StDone:  state_d = cs_d_q ? StIdle : StShift;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        a0_byte_d   = a0_byte_q;
        page_d      = page_q;
        col_d       = col_q;
        rx_data_d   = rx_data_q;
        rx_a0_d     = rx_a0_q;
        rx_valid_d  = 1'b0;
        cmd_valid_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: if (cs_fall_q) cnt_d = '0;
            StShift: begin
                if (cs_rise_q) begin
                    frame_err_d = (cnt_q != 3'd0);
                    cnt_d       = '0;
                end else if (sclk_rise_q) begin
                    shift_d = {shift_q[6:0], sda_q};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) a0_byte_d = a0_q;
                end
            end
            StDone: begin
                cnt_d      = '0;
                rx_valid_d = 1'b1;
                rx_data_d  = shift_q;
                rx_a0_d    = a0_byte_q;
                if (a0_byte_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {page_q, col_q};
                    wr_data_d = shift_q;
                    col_d     = (col_q == ColLast) ? 7'd0 : col_q + 7'd1;
                end else begin
                    cmd_valid_d = 1'b1;
                    case (shift_q[7:4])
                        4'hB: if ({28'd0, shift_q[3:0]} <= PAGE_MAX) page_d = shift_q[2:0];
                        4'h1: col_d[6:4] = shift_q[2:0];
                        4'h0: col_d[3:0] = shift_q[3:0];
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            a0_byte_q   <= 1'b0;
            page_q      <= '0;
            col_q       <= '0;
            rx_data_q   <= '0;
            rx_a0_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            a0_byte_q   <= a0_byte_d;
            page_q      <= page_d;
            col_q       <= col_d;
            rx_data_q   <= rx_data_d;
            rx_a0_q     <= rx_a0_d;
            rx_valid_q  <= rx_valid_d;
            cmd_valid_q <= cmd_valid_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign Rx_Data   = rx_data_q;
    assign Rx_A0     = rx_a0_q;
    assign Rx_Valid  = rx_valid_q;
    assign Cmd_Valid = cmd_valid_q;
    assign Wr_En     = wr_en_q;
    assign Wr_Addr   = wr_addr_q;
    assign Wr_Data   = wr_data_q;
    assign Frame_Err = frame_err_q;

endmodule

// File: tb/tb_spi_lcd_rx_module.sv
// Bench for spi_lcd_rx_module: bit-banged SPI frames against a pointer/write model,
// with a second instance at SYNC_STAGES=3 for the latency comparison.
module tb_spi_lcd_rx_module;

    localparam int H = 5;  // SCLK half period in CLK cycles

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       spi_cs, spi_a0, spi_sclk, spi_sda;
    logic [3:0] spi_in;
    assign spi_in = {spi_cs, spi_a0, spi_sclk, spi_sda};

    logic [7:0] Rx_Data, Wr_Data, rx_data3, wr_data3;
    logic       Rx_A0, Rx_Valid, Cmd_Valid, Wr_En, Frame_Err;
    logic       rx_a03, rx_valid3, cmd_valid3, wr_en3, frame_err3;
    logic [9:0] Wr_Addr, wr_addr3;

    spi_lcd_rx_module #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RSTn(RSTn), .SPI_In(spi_in),
        .Rx_Data(Rx_Data), .Rx_A0(Rx_A0), .Rx_Valid(Rx_Valid), .Cmd_Valid(Cmd_Valid),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Frame_Err(Frame_Err)
    );

    spi_lcd_rx_module #(.SYNC_STAGES(3)) dut3 (
        .CLK(CLK), .RSTn(RSTn), .SPI_In(spi_in),
        .Rx_Data(rx_data3), .Rx_A0(rx_a03), .Rx_Valid(rx_valid3), .Cmd_Valid(cmd_valid3),
        .Wr_En(wr_en3), .Wr_Addr(wr_addr3), .Wr_Data(wr_data3), .Frame_Err(frame_err3)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       a0;
        logic       cmd;
        logic       wr;
        logic [9:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0;
    int   cnt_rx = 0, cnt_wr = 0, cnt_cmd = 0, cnt_ferr = 0;
    int   exp_rx = 0, exp_wr = 0, exp_cmd = 0, exp_ferr = 0;
    int   m_page = 0, m_col = 0;
    logic [7:0] last_rx = '0, last_wdata = '0;
    logic       last_a0 = 1'b0;
    logic [9:0] last_addr = '0;
    bit   measure = 0;
    int   lat2, lat3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: what a byte does to the LCD pointer and what the DUT must report.
    task automatic model_byte(input logic a0v, input logic [7:0] b);
        exp_t e;
        int   hi = int'(b) / 16;
        int   lo = int'(b) % 16;
        e.data = b; e.a0 = a0v; e.cmd = ~a0v; e.wr = a0v; e.addr = '0;
        exp_rx++;
        if (a0v) begin
            e.addr = 10'(m_page * 128 + m_col);
            m_col  = (m_col + 1) % 128;
            exp_wr++;
            last_addr  = e.addr;
            last_wdata = b;
        end else begin
            exp_cmd++;
            if (hi == 11 && lo <= 7) m_page = lo;
            else if (hi == 1)        m_col = (m_col % 16) + (lo % 8) * 16;
            else if (hi == 0)        m_col = (m_col / 16) * 16 + lo;
        end
        last_rx = b;
        last_a0 = a0v;
        exp_q.push_back(e);
    endtask

    always @(posedge CLK) begin
        #1;
        if (Rx_Valid === 1'b1) begin
            cnt_rx++;
            if (exp_q.size() == 0) begin
                chk("rx_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", Rx_Data, e.data);
                chk("rx_a0", Rx_A0, e.a0);
                chk("cmd_valid", Cmd_Valid, e.cmd);
                chk("wr_en", Wr_En, e.wr);
                if (e.wr) begin
                    chk("wr_addr", Wr_Addr, e.addr);
                    chk("wr_data", Wr_Data, e.data);
                end
            end
        end
        if (Wr_En === 1'b1)     cnt_wr++;
        if (Cmd_Valid === 1'b1) cnt_cmd++;
        if (Frame_Err === 1'b1) cnt_ferr++;
    end

    task automatic cs_low();
        @(negedge CLK); spi_cs = 1'b0;
        repeat (H) @(negedge CLK);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge CLK); spi_cs = 1'b1;
        repeat (H) @(negedge CLK);
    endtask

    task automatic send_bits(input logic a0v, input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge CLK);
            spi_sda = v[i];
            spi_a0  = a0v;
            repeat (H) @(negedge CLK);
            spi_sclk = 1'b1;
            if (i == 0 && measure) begin
                @(posedge CLK);  // first edge that samples the 8th SCLK high
                for (int n = 1; n <= 12; n++) begin
                    @(posedge CLK); #1;
                    if (Rx_Valid === 1'b1 && lat2 < 0)  lat2 = n;
                    if (rx_valid3 === 1'b1 && lat3 < 0) lat3 = n;
                end
                @(negedge CLK);
            end else begin
                repeat (H) @(negedge CLK);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic a0v, input logic [7:0] v);
        model_byte(a0v, v);
        send_bits(a0v, v, 8);
    endtask

    task automatic end_check(input string tag);
        repeat (20) @(negedge CLK);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_n_rx"}, 32'(cnt_rx), 32'(exp_rx));
        chk({tag, "_n_wr"}, 32'(cnt_wr), 32'(exp_wr));
        chk({tag, "_n_cmd"}, 32'(cnt_cmd), 32'(exp_cmd));
        chk({tag, "_n_ferr"}, 32'(cnt_ferr), 32'(exp_ferr));
        chk({tag, "_hold_rx"}, Rx_Data, last_rx);
        chk({tag, "_hold_a0"}, Rx_A0, last_a0);
        chk({tag, "_hold_addr"}, Wr_Addr, last_addr);
        chk({tag, "_hold_wdata"}, Wr_Data, last_wdata);
        chk({tag, "_s3_rx"}, rx_data3, last_rx);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        RSTn = 1'b0;
        spi_cs = 1'b1; spi_a0 = 1'b0; spi_sclk = 1'b0; spi_sda = 1'b0;
        repeat (5) @(negedge CLK);
        chk("rst_rx_data", Rx_Data, 8'h00);
        chk("rst_rx_valid", Rx_Valid, 1'b0);
        chk("rst_wr_addr", Wr_Addr, 10'd0);
        chk("rst_frame_err", Frame_Err, 1'b0);
        RSTn = 1'b1;
        repeat (10) @(negedge CLK);

        // Page/column commands followed by data
        cs_low();
        send_byte(1'b0, 8'hB3); send_byte(1'b0, 8'h12); send_byte(1'b0, 8'h05);
        send_byte(1'b1, 8'hA5);
        repeat (10) @(negedge CLK);
        chk("t1_addr", Wr_Addr, 10'd421);
        chk("t1_data", Wr_Data, 8'hA5);
        send_byte(1'b1, 8'h5A);
        repeat (10) @(negedge CLK);
        chk("t1_next_addr", Wr_Addr, 10'd422);
        cs_high();
        end_check("t1");

        // Column wrap at the last column
        cs_low();
        send_byte(1'b0, 8'hB2); send_byte(1'b0, 8'h17); send_byte(1'b0, 8'h0F);
        send_byte(1'b1, 8'h11);
        repeat (10) @(negedge CLK);
        chk("t2_addr_last", Wr_Addr, 10'd383);
        send_byte(1'b1, 8'h22);
        repeat (10) @(negedge CLK);
        chk("t2_addr_wrap", Wr_Addr, 10'd256);
        cs_high();
        end_check("t2");

        // Truncated frame, then a good one
        cs_low();
        send_bits(1'b1, 8'hFF, 5);
        exp_ferr++;
        cs_high();
        cs_low();
        send_byte(1'b1, 8'h3C);
        cs_high();
        end_check("t3");

        // Unrecognised command and out-of-range page leave the pointer alone
        cs_low();
        send_byte(1'b0, 8'hAF); send_byte(1'b0, 8'hB9); send_byte(1'b1, 8'h77);
        cs_high();
        end_check("t4");

        // Latency for both synchroniser depths, and SCLK ignored while deselected
        lat2 = -1; lat3 = -1;
        cs_low();
        measure = 1;
        send_byte(1'b1, 8'hC3);
        measure = 0;
        cs_high();
        chk("t5_latency_s2", 32'(lat2), 32'd4);
        chk("t5_latency_s3", 32'(lat3), 32'd5);
        for (int i = 0; i < 16; i++) begin
            spi_sda = 1'($urandom);
            repeat (H) @(negedge CLK); spi_sclk = 1'b1;
            repeat (H) @(negedge CLK); spi_sclk = 1'b0;
        end
        end_check("t5");

        // Reset in the middle of a byte
        cs_low();
        send_bits(1'b1, 8'hF0, 4);
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        chk("t6_rst_rx_data", Rx_Data, 8'h00);
        chk("t6_rst_rx_a0", Rx_A0, 1'b0);
        chk("t6_rst_rx_valid", Rx_Valid, 1'b0);
        chk("t6_rst_cmd_valid", Cmd_Valid, 1'b0);
        chk("t6_rst_wr_en", Wr_En, 1'b0);
        chk("t6_rst_wr_addr", Wr_Addr, 10'd0);
        chk("t6_rst_wr_data", Wr_Data, 8'h00);
        chk("t6_rst_frame_err", Frame_Err, 1'b0);
        m_page = 0; m_col = 0;
        last_rx = '0; last_a0 = 1'b0; last_addr = '0; last_wdata = '0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        cs_high();
        cs_low();
        send_byte(1'b1, 8'h80);
        repeat (10) @(negedge CLK);
        chk("t6_addr", Wr_Addr, 10'd0);
        chk("t6_data", Wr_Data, 8'h80);
        cs_high();
        end_check("t6");

        // Random traffic
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                cs_low();
                send_bits(1'($urandom), 8'($urandom), $urandom_range(1, 7));
                exp_ferr++;
                cs_high();
            end
            cs_low();
            for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                logic       a0v;
                logic [7:0] v;
                a0v = 1'($urandom);
                case ($urandom_range(0, 3))
                    0:       v = 8'hB0 | 8'($urandom_range(0, 15));
                    1:       v = 8'h10 | 8'($urandom_range(0, 15));
                    2:       v = 8'($urandom_range(0, 15));
                    default: v = 8'($urandom);
                endcase
                send_byte(a0v, v);
            end
            cs_high();
        end
        end_check("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
